rf_decode_param: RTL and testbench

//   Parametrised decode-stage register file: NRD read ports, one write port,
//   per-register busy scoreboard for in-flight writes, and immediate/address

---
 rtl/rf_decode_pkg.sv | 27 ++
 rtl/rf_scoreboard.sv | 55 +++++
 rtl/rf_decode_param.sv | 107 ++++++++++
 tb/tb_rf_decode_param.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/rf_decode_pkg.sv
// Shared constants and helpers for the decode-stage register file.
// sext() zero-pads its input to SEXT_MAX bits and replicates bit in_w-1 above it.
package rf_decode_pkg;

  localparam int RF_WIDTH_DEF = 16;
  localparam int RF_NREGS_DEF = 8;
  localparam int SEXT_MAX     = 64;

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [SEXT_MAX-1:0] sext(input logic [SEXT_MAX-1:0] in, input int in_w);
    logic [SEXT_MAX-1:0] out;
    logic                msb;
    msb = 1'b0;
    for (int b = 0; b < SEXT_MAX; b++) begin
      if (b == in_w - 1) msb = in[b];
    end
    out = '0;
    for (int b = 0; b < SEXT_MAX; b++) begin
      out[b] = (b < in_w) ? in[b] : msb;
    end
    return out;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for in-flight long-latency writes, looked up per read port.
// With RF_BYPASS_EN defined, a same-cycle write to the read register hides its busy bit.
module rf_scoreboard
  import rf_decode_pkg::*;
#(
  parameter int NREGS = RF_NREGS_DEF,
  parameter int NRD   = 2,
  parameter int SEL_W = sel_width(NREGS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 write_i,
  input  logic [SEL_W-1:0]     write_sel_i,
  input  logic                 reserve_i,
  input  logic [SEL_W-1:0]     reserve_sel_i,
  input  logic [NRD*SEL_W-1:0] rd_sel_i,
  output logic [NRD-1:0]       busy_o
);

  logic [NREGS-1:0] busy_q, busy_d;

  // A reservation landing with a write to the same register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NREGS; r++) begin
      if (reserve_i && reserve_sel_i == SEL_W'(r))
        busy_d[r] = 1'b1;
      else if (write_i && write_sel_i == SEL_W'(r))
        busy_d[r] = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_lookup
    logic [SEL_W-1:0] sel;
    logic             bit_b;
    assign sel = rd_sel_i[i*SEL_W +: SEL_W];
    always_comb begin
      bit_b = 1'b0;
      for (int r = 0; r < NREGS; r++) begin
        if (sel == SEL_W'(r)) bit_b = busy_q[r];
      end
`ifdef RF_BYPASS_EN
      if (write_i && write_sel_i == sel && !(reserve_i && reserve_sel_i == sel))
        bit_b = 1'b0;
`endif
    end
    assign busy_o[i] = bit_b;
  end

endmodule

// File: rtl/rf_decode_param.sv
// Parametrised decode register file: NRD comb read ports, one write port, busy scoreboard,
// sticky out-of-range error and Imm/Address sign extension. RF_BYPASS_EN enables write forwarding.
module rf_decode_param
  import rf_decode_pkg::*;
#(
  parameter int WIDTH  = RF_WIDTH_DEF,
  parameter int NREGS  = RF_NREGS_DEF,
  parameter int NRD    = 2,
  parameter int IMM_W  = 8,
  parameter int ADDR_W = 11,
  localparam int SEL_W = sel_width(NREGS)
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [NRD*SEL_W-1:0] RdSel,
  output logic [NRD*WIDTH-1:0] RdData,
  output logic [NRD-1:0]       Busy,
  output logic                 Stall,
  input  logic                 Write,
  input  logic [SEL_W-1:0]     WriteSel,
  input  logic [WIDTH-1:0]     WriteData,
  input  logic                 Reserve,
  input  logic [SEL_W-1:0]     ReserveSel,
  input  logic [IMM_W-1:0]     Imm,
  input  logic [ADDR_W-1:0]    Address,
  output logic [WIDTH-1:0]     ImmExt,
  output logic [WIDTH-1:0]     AddressExt,
  output logic                 Err
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic             err_q, err_d;
  logic             rd_bad;

  // Loop-based so non-power-of-two NREGS never indexes past the array.
  function automatic logic sel_ok(input logic [SEL_W-1:0] s);
    logic ok;
    ok = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      if (s == SEL_W'(r)) ok = 1'b1;
    end
    return ok;
  endfunction

  always_comb begin
    regs_d = regs_q;
    for (int r = 0; r < NREGS; r++) begin
      if (Write && WriteSel == SEL_W'(r)) regs_d[r] = WriteData;
    end
  end

  always_comb begin
    rd_bad = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      if (!sel_ok(RdSel[i*SEL_W +: SEL_W])) rd_bad = 1'b1;
    end
    err_d = err_q | (Write & ~sel_ok(WriteSel)) | (Reserve & ~sel_ok(ReserveSel)) | rd_bad;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
      err_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      err_q  <= err_d;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] data;
    assign sel = RdSel[i*SEL_W +: SEL_W];
    always_comb begin
      data = '0;
      for (int r = 0; r < NREGS; r++) begin
        if (sel == SEL_W'(r)) data = regs_q[r];
      end
`ifdef RF_BYPASS_EN
      if (Write && WriteSel == sel && sel_ok(sel)) data = WriteData;
`endif
    end
    assign RdData[i*WIDTH +: WIDTH] = data;
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .SEL_W (SEL_W)
  ) u_sb (
    .clk_i         (Clk),
    .rst_i         (Rst),
    .write_i       (Write),
    .write_sel_i   (WriteSel),
    .reserve_i     (Reserve),
    .reserve_sel_i (ReserveSel),
    .rd_sel_i      (RdSel),
    .busy_o        (Busy)
  );

  assign Stall      = |Busy;
  assign Err        = err_q;
  assign ImmExt     = WIDTH'(sext(SEXT_MAX'(Imm), IMM_W));
  assign AddressExt = WIDTH'(sext(SEXT_MAX'(Address), ADDR_W));

endmodule

// File: tb/tb_rf_decode_param.sv
// Scoreboard bench for rf_decode_param (WIDTH=16, NREGS=6, NRD=2): directed vectors, then a
// random phase against an array model. Expectations follow RF_BYPASS_EN if defined.
module tb_rf_decode_param;

  localparam int W  = 16;
  localparam int N  = 6;
  localparam int NR = 2;
  localparam int SW = 3;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Rst;
  logic [NR*SW-1:0] RdSel;
  logic [NR*W-1:0]  RdData;
  logic [NR-1:0] Busy;
  logic          Stall;
  logic          Write;
  logic [SW-1:0] WriteSel;
  logic [W-1:0]  WriteData;
  logic          Reserve;
  logic [SW-1:0] ReserveSel;
  logic [7:0]    Imm;
  logic [10:0]   Address;
  logic [W-1:0]  ImmExt;
  logic [W-1:0]  AddressExt;
  logic          Err;

  rf_decode_param #(.WIDTH(W), .NREGS(N), .NRD(NR), .IMM_W(8), .ADDR_W(11)) dut (
    .Clk(Clk), .Rst(Rst), .RdSel(RdSel), .RdData(RdData), .Busy(Busy), .Stall(Stall),
    .Write(Write), .WriteSel(WriteSel), .WriteData(WriteData), .Reserve(Reserve),
    .ReserveSel(ReserveSel), .Imm(Imm), .Address(Address), .ImmExt(ImmExt),
    .AddressExt(AddressExt), .Err(Err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       nm;
    logic [15:0] rd0, rd1;
    logic [1:0]  busy;
    logic [15:0] imm, adr;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  logic [15:0] m_reg [N];
  logic        m_busy [N];

  task automatic chk(string nm, string fld, logic [31:0] act, logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, expv);
  endtask

  // Monitor: combinational outputs of the cycle are sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.nm, "rd0",   32'(RdData[15:0]),  32'(e.rd0));
        chk(e.nm, "rd1",   32'(RdData[31:16]), 32'(e.rd1));
        chk(e.nm, "busy",  32'(Busy),          32'(e.busy));
        chk(e.nm, "stall", 32'(Stall),         32'(|e.busy));
        chk(e.nm, "imm",   32'(ImmExt),        32'(e.imm));
        chk(e.nm, "adr",   32'(AddressExt),    32'(e.adr));
        chk(e.nm, "err",   32'(Err),           32'(e.err));
      end
    end
  end

  task automatic step(string nm, bit rst, bit wr, int ws, int wd, bit rs, int rss, int s0, int s1,
                      int imm, int adr, int e0, int e1, int eb, int eimm, int eadr, bit eerr);
    exp_t e;
    Rst = rst; Write = wr; WriteSel = SW'(ws); WriteData = W'(wd);
    Reserve = rs; ReserveSel = SW'(rss); RdSel = {SW'(s1), SW'(s0)};
    Imm = 8'(imm); Address = 11'(adr);
    e.nm = nm; e.rd0 = 16'(e0); e.rd1 = 16'(e1); e.busy = 2'(eb);
    e.imm = 16'(eimm); e.adr = 16'(eadr); e.err = eerr;
    q.push_back(e);
    @(posedge Clk);
    #1;
  endtask

  task automatic d(string nm, bit rst, bit wr, int ws, int wd, bit rs, int rss, int s0, int s1,
                   int e0, int e1, int eb, bit eerr);
    step(nm, rst, wr, ws, wd, rs, rss, s0, s1, 0, 0, e0, e1, eb, 0, 0, eerr);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    Rst = 1'b1; Write = 1'b0; WriteSel = '0; WriteData = '0; Reserve = 1'b0;
    ReserveSel = '0; RdSel = '0; Imm = '0; Address = '0;
    repeat (2) @(posedge Clk);
    #1;

    d("w1",   0, 1, 1, 'h1111, 0, 0, 1, 3, BYP ? 'h1111 : 0, 0, 0, 0);
    d("w3",   0, 1, 3, 'h2222, 0, 0, 1, 3, 'h1111, BYP ? 'h2222 : 0, 0, 0);
    d("res2", 0, 0, 0, 0, 1, 2, 1, 3, 'h1111, 'h2222, 0, 0);
    d("rst1", 1, 1, 4, 'h4444, 1, 4, 2, 3, 0, 'h2222, 1, 0);
    d("rst2", 1, 1, 4, 'h4444, 1, 4, 2, 3, 0, 0, 0, 0);
    d("post", 0, 0, 0, 0, 0, 0, 4, 3, 0, 0, 0, 0);
    d("beef_same", 0, 1, 3, 'hBEEF, 0, 0, 3, 0, BYP ? 'hBEEF : 0, 0, 0, 0);
    d("beef_next", 0, 0, 0, 0, 0, 0, 3, 0, 'hBEEF, 0, 0, 0);
    d("res5",      0, 0, 0, 0, 1, 5, 3, 5, 'hBEEF, 0, 0, 0);
    d("busy5",     0, 0, 0, 0, 0, 0, 3, 5, 'hBEEF, 0, 2, 0);
    d("w5",        0, 1, 5, 7, 0, 0, 3, 5, 'hBEEF, BYP ? 7 : 0, BYP ? 0 : 2, 0);
    d("w5_next",   0, 0, 0, 0, 0, 0, 3, 5, 'hBEEF, 7, 0, 0);
    d("rw5",       0, 1, 5, 9, 1, 5, 3, 5, 'hBEEF, BYP ? 9 : 7, 0, 0);
    d("rw5_next",  0, 0, 0, 0, 0, 0, 3, 5, 'hBEEF, 9, 2, 0);
    d("res5_again",0, 0, 0, 0, 1, 5, 5, 5, 9, 9, 3, 0);
    d("still5",    0, 0, 0, 0, 0, 0, 5, 5, 9, 9, 3, 0);
    d("w5b",       0, 1, 5, 'h11, 0, 0, 5, 3, BYP ? 'h11 : 9, 'hBEEF, BYP ? 0 : 1, 0);
    d("w5b_next",  0, 0, 0, 0, 0, 0, 5, 3, 'h11, 'hBEEF, 0, 0);
    step("sext_neg", 0, 0, 0, 0, 0, 0, 3, 5, 'h80, 'h3FF, 'hBEEF, 'h11, 0, 'hFF80, 'h03FF, 0);
    step("sext_pos", 0, 0, 0, 0, 0, 0, 3, 5, 'h7F, 'h400, 'hBEEF, 'h11, 0, 'h007F, 'hFC00, 0);

    d("wbad",       0, 1, 7, 'hFFFF, 0, 0, 1, 5, 0, 'h11, 0, 0);
    d("err_set",    0, 0, 0, 0, 0, 0, 1, 5, 0, 'h11, 0, 1);
    d("err_hold",   0, 0, 0, 0, 0, 0, 3, 5, 'hBEEF, 'h11, 0, 1);
    d("rst_err",    1, 0, 0, 0, 0, 0, 3, 5, 'hBEEF, 'h11, 0, 1);
    d("err_clr",    0, 0, 0, 0, 0, 0, 3, 5, 0, 0, 0, 0);
    d("rdbad",      0, 0, 0, 0, 0, 0, 6, 7, 0, 0, 0, 0);
    d("rdbad_err",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    d("rst3",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    d("resbad",     0, 0, 0, 0, 1, 6, 0, 0, 0, 0, 0, 0);
    d("resbad_err", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    d("rst4",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    d("clean",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int r = 0; r < N; r++) begin
      m_reg[r] = '0;
      m_busy[r] = 1'b0;
    end
    for (int c = 0; c < 300; c++) begin
      bit          wr, rs, b0, b1;
      int          ws, rss, s0, s1;
      logic [15:0] wd, e0, e1;
      logic [7:0]  i8;
      logic [10:0] a11;
      wr = 1'($urandom_range(0, 1)); ws = $urandom_range(0, N - 1); wd = 16'($urandom);
      rs = ($urandom_range(0, 3) == 0); rss = $urandom_range(0, N - 1);
      s0 = $urandom_range(0, N - 1); s1 = $urandom_range(0, N - 1);
      i8 = 8'($urandom); a11 = 11'($urandom);
      e0 = (BYP && wr && ws == s0) ? wd : m_reg[s0];
      e1 = (BYP && wr && ws == s1) ? wd : m_reg[s1];
      b0 = (BYP && wr && ws == s0 && !(rs && rss == s0)) ? 1'b0 : m_busy[s0];
      b1 = (BYP && wr && ws == s1 && !(rs && rss == s1)) ? 1'b0 : m_busy[s1];
      step("rand", 0, wr, ws, int'(wd), rs, rss, s0, s1, int'(i8), int'(a11), int'(e0), int'(e1),
           int'({b1, b0}), int'({{8{i8[7]}}, i8}), int'({{5{a11[10]}}, a11}), 0);
      if (rs) m_busy[rss] = 1'b1;
      if (wr) begin
        m_reg[ws] = wd;
        if (!(rs && rss == ws)) m_busy[ws] = 1'b0;
      end
    end

    Write = 1'b0; Reserve = 1'b0;
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge Clk);
    #1;
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain actual=%0d pending required=0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
